// File: rtl/ps2_keyboard_rx_multi.sv
// PS/2 keyboard receiver: pin conditioning, framed RX FSM, E0/F0 decoder, held-key table, event FIFO.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection of received bytes.
module ps2_keyboard_rx_multi #(
  parameter int N_KEYS         = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  iCLK_50,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_dat,
  input  logic                  key_clr,
  input  logic                  evt_ready,
  output logic                  evt_valid,
  output logic [7:0]            evt_code,
  output logic                  evt_ext,
  output logic                  evt_break,
  output logic [N_KEYS-1:0]     key_on,
  output logic [9*N_KEYS-1:0]   key_code,
  output logic                  frame_err,
  output logic                  overflow
);
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_clk_filt;
  logic [FCW-1:0]  r_filt_cnt;
  logic            w_flip, w_fall;

  assign w_flip = (r_clk_s2 != r_clk_filt) && (r_filt_cnt == FCW'(FILTER_LEN - 1));
  assign w_fall = w_flip && r_clk_filt;

  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
      // Any sample agreeing with the filtered level restarts the run count
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (w_flip) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  state_t          r_state;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic [TCW-1:0]  r_to_cnt;
  logic            r_byte_vld;
  logic [7:0]      r_byte;
  logic            r_frame_err;
  logic            w_par_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic            r_par;
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_to_cnt    <= '0;
      r_byte_vld  <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end
          end
          S_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_par   <= r_dat_s2;
`endif
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!r_dat_s2 || !w_par_ok) begin
              r_frame_err <= 1'b1;
            end else begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_shift;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
          r_state     <= S_IDLE;
          r_frame_err <= 1'b1;
          r_to_cnt    <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

  // Prefix flags survive frame errors; only a non-prefix byte consumes them
  logic       r_ext, r_brk, r_evt_vld, r_evt_ext, r_evt_brk;
  logic [7:0] r_evt_code;

  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_evt_vld  <= 1'b0;
      r_evt_ext  <= 1'b0;
      r_evt_brk  <= 1'b0;
      r_evt_code <= '0;
    end else begin
      r_evt_vld <= 1'b0;
      if (r_byte_vld) begin
        if (r_byte == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_byte == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_evt_vld  <= 1'b1;
          r_evt_code <= r_byte;
          r_evt_ext  <= r_ext;
          r_evt_brk  <= r_brk;
          r_ext      <= 1'b0;
          r_brk      <= 1'b0;
        end
      end
    end
  end

  logic [N_KEYS-1:0] r_on;
  logic [8:0]        r_kc [N_KEYS];
  logic [8:0]        w_key;
  logic [N_KEYS-1:0] w_match, w_free, w_sel;
  logic              w_tbl_ovf;

  assign w_key  = {r_evt_ext, r_evt_code};
  assign w_free = ~r_on;
  assign w_sel  = w_free & (~w_free + 1'b1);  // lowest-index free slot, one-hot
  assign w_tbl_ovf = r_evt_vld && !r_evt_brk && !key_clr && !(|w_match) && !(|w_free);

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_slot
      assign w_match[gi]            = r_on[gi] && (r_kc[gi] == w_key);
      assign key_code[9*gi +: 9]    = r_kc[gi];
    end
  endgenerate
  assign key_on = r_on;

  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      r_on <= '0;
      for (int i = 0; i < N_KEYS; i++) r_kc[i] <= '0;
    end else if (key_clr) begin
      r_on <= '0;
      for (int i = 0; i < N_KEYS; i++) r_kc[i] <= '0;
    end else if (r_evt_vld) begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (r_evt_brk) begin
          if (w_match[i]) begin
            r_on[i] <= 1'b0;
            r_kc[i] <= '0;
          end
        end else if (!(|w_match) && w_sel[i]) begin
          r_on[i] <= 1'b1;
          r_kc[i] <= w_key;
        end
      end
    end
  end

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_pop, w_full, w_push, w_drop;
  logic [9:0]    w_head;

  assign evt_valid = (r_count != '0);
  assign w_pop     = evt_valid && evt_ready;
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_push    = r_evt_vld && (!w_full || w_pop);
  assign w_drop    = r_evt_vld && w_full && !w_pop;
  assign w_head    = evt_valid ? r_mem[r_rptr] : 10'd0;
  assign evt_ext   = w_head[9];
  assign evt_break = w_head[8];
  assign evt_code  = w_head[7:0];

  always_ff @(posedge iCLK_50) begin
    if (w_push) r_mem[r_wptr] <= {r_evt_ext, r_evt_brk, r_evt_code};
  end

  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= AW'((int'(r_wptr) + 1) % FIFO_DEPTH);
      if (w_pop)  r_rptr <= AW'((int'(r_rptr) + 1) % FIFO_DEPTH);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      r_overflow <= w_tbl_ovf || w_drop;
    end
  end

  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_keyboard_rx_multi.sv
// Bench for ps2_keyboard_rx_multi: directed vector table, corner sequences, randomized frames vs a reference model.
// Expectations follow PS2_PARITY_CHECK_EN when the bench is compiled with it.
module tb_ps2_keyboard_rx_multi;
  localparam int N_KEYS = 3, FIFO_DEPTH = 4, FILTER_LEN = 8, TIMEOUT = 1000;
  localparam int HALF = 10, GAP = 30;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1, key_clr = 1'b0, evt_ready = 1'b1;
  logic evt_valid, evt_ext, evt_break, frame_err, overflow;
  logic [7:0] evt_code;
  logic [N_KEYS-1:0] key_on;
  logic [9*N_KEYS-1:0] key_code;

  always #5 clk = ~clk;

  ps2_keyboard_rx_multi #(.N_KEYS(N_KEYS), .FIFO_DEPTH(FIFO_DEPTH), .FILTER_LEN(FILTER_LEN),
                          .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .iCLK_50(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .key_clr(key_clr),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext),
    .evt_break(evt_break), .key_on(key_on), .key_code(key_code), .frame_err(frame_err),
    .overflow(overflow));

  int n_chk = 0, n_fail = 0;
  logic [9:0] mon_q[$];
  int err_total = 0, ovf_total = 0;

  // Observed stream: accepted events {ext,brk,code} and pulse counts
  always @(negedge clk) begin
    if (evt_valid && evt_ready) mon_q.push_back({evt_ext, evt_break, evt_code});
    if (frame_err) err_total++;
    if (overflow) ovf_total++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(mk_frame(b, bad_par, bad_stop), 11);
    ps2_dat = 1'b1;
    tick(HALF + GAP);
  endtask

  task automatic pulse_clr();
    key_clr = 1'b1;
    tick(1);
    key_clr = 1'b0;
    tick(1);
  endtask

  function automatic logic [26:0] kc3(input logic [8:0] s2, input logic [8:0] s1, input logic [8:0] s0);
    return {s2, s1, s0};
  endfunction

  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    bit          bad_stop;
    bit          ev_v;
    logic [9:0]  ev;
    int          err;
    int          ovf;
    logic [2:0]  on;
    logic [26:0] kc;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [7:0] b, input bit bp, input bit bs, input bit ev_v, input logic [9:0] ev,
                     input int err, input int ovf, input logic [2:0] on, input logic [26:0] kc);
    vec_t v;
    v.b = b; v.bad_par = bp; v.bad_stop = bs; v.ev_v = ev_v; v.ev = ev;
    v.err = err; v.ovf = ovf; v.on = on; v.kc = kc;
    vecs.push_back(v);
  endtask

  // Reference model: prefix flags, slot table, expected event list
  bit         m_ext, m_brk;
  bit         m_on [N_KEYS];
  logic [8:0] m_kc [N_KEYS];
  logic [9:0] m_evq[$];
  int         m_err, m_ovf;

  task automatic model_clr();
    for (int i = 0; i < N_KEYS; i++) begin m_on[i] = 0; m_kc[i] = '0; end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int hit;
    int fr;
    if (bad_stop || (bad_par && PAR_EN)) begin
      m_err++;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      m_evq.push_back({m_ext, m_brk, b});
      hit = -1; fr = -1;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
        if (m_on[i] && m_kc[i] == {m_ext, b}) hit = i;
        if (!m_on[i]) fr = i;
      end
      if (m_brk) begin
        if (hit >= 0) begin m_on[hit] = 0; m_kc[hit] = '0; end
      end else if (hit < 0) begin
        if (fr >= 0) begin m_on[fr] = 1; m_kc[fr] = {m_ext, b}; end
        else m_ovf++;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  function automatic logic [26:0] model_kc();
    logic [26:0] r;
    r = '0;
    for (int i = 0; i < N_KEYS; i++) r[9*i +: 9] = m_kc[i];
    return r;
  endfunction

  function automatic logic [2:0] model_on();
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < N_KEYS; i++) r[i] = m_on[i];
    return r;
  endfunction

  initial begin
    int e0, o0, m0, pick;
    logic [7:0] pool [6];
    logic [7:0] bp_codes [5];
    logic [7:0] b;
    bit bs, bpar;

    // Reset state
    tick(3);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_word", {evt_ext, evt_break, evt_code}, 0);
    chk("rst_key_on", key_on, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_err_ovf", {frame_err, overflow}, 0);
    reset = 1'b1;
    tick(3);

    add(8'h1C, 0, 0, 1, 10'h01C, 0, 0, 3'b001, kc3(0, 0, 9'h01C));
    add(8'h74, 0, 0, 1, 10'h074, 0, 0, 3'b011, kc3(0, 9'h074, 9'h01C));
    add(8'hE0, 0, 0, 0, 10'h000, 0, 0, 3'b011, kc3(0, 9'h074, 9'h01C));
    add(8'h74, 0, 0, 1, 10'h274, 0, 0, 3'b111, kc3(9'h174, 9'h074, 9'h01C));
    add(8'hE0, 0, 0, 0, 10'h000, 0, 0, 3'b111, kc3(9'h174, 9'h074, 9'h01C));
    add(8'hF0, 0, 0, 0, 10'h000, 0, 0, 3'b111, kc3(9'h174, 9'h074, 9'h01C));
    add(8'h74, 0, 0, 1, 10'h374, 0, 0, 3'b011, kc3(0, 9'h074, 9'h01C));
    add(8'hF0, 0, 0, 0, 10'h000, 0, 0, 3'b011, kc3(0, 9'h074, 9'h01C));
    add(8'h1C, 0, 0, 1, 10'h11C, 0, 0, 3'b010, kc3(0, 9'h074, 0));
    add(8'hF0, 0, 0, 0, 10'h000, 0, 0, 3'b010, kc3(0, 9'h074, 0));
    add(8'h74, 0, 0, 1, 10'h174, 0, 0, 3'b000, kc3(0, 0, 0));
    add(8'h16, 0, 0, 1, 10'h016, 0, 0, 3'b001, kc3(0, 0, 9'h016));
    add(8'h1E, 0, 0, 1, 10'h01E, 0, 0, 3'b011, kc3(0, 9'h01E, 9'h016));
    add(8'h26, 0, 0, 1, 10'h026, 0, 0, 3'b111, kc3(9'h026, 9'h01E, 9'h016));
    add(8'h25, 0, 0, 1, 10'h025, 0, 1, 3'b111, kc3(9'h026, 9'h01E, 9'h016));
    add(8'hF0, 0, 0, 0, 10'h000, 0, 0, 3'b111, kc3(9'h026, 9'h01E, 9'h016));
    add(8'h1E, 0, 0, 1, 10'h11E, 0, 0, 3'b101, kc3(9'h026, 0, 9'h016));
    add(8'h25, 0, 0, 1, 10'h025, 0, 0, 3'b111, kc3(9'h026, 9'h025, 9'h016));
    add(8'h5A, 0, 1, 0, 10'h000, 1, 0, 3'b111, kc3(9'h026, 9'h025, 9'h016));
    add(8'h5A, 1, 0, !PAR_EN, 10'h05A, int'(PAR_EN), int'(!PAR_EN), 3'b111, kc3(9'h026, 9'h025, 9'h016));
    add(8'hE0, 0, 0, 0, 10'h000, 0, 0, 3'b111, kc3(9'h026, 9'h025, 9'h016));
    add(8'h12, 0, 1, 0, 10'h000, 1, 0, 3'b111, kc3(9'h026, 9'h025, 9'h016));
    add(8'h12, 0, 0, 1, 10'h212, 0, 1, 3'b111, kc3(9'h026, 9'h025, 9'h016));

    foreach (vecs[k]) begin
      e0 = err_total; o0 = ovf_total; m0 = mon_q.size();
      send_frame(vecs[k].b, vecs[k].bad_par, vecs[k].bad_stop);
      $display("vec %0d: byte %02h bp=%0d bs=%0d events=%0d err=%0d ovf=%0d key_on=%b", k, vecs[k].b,
               vecs[k].bad_par, vecs[k].bad_stop, mon_q.size() - m0, err_total - e0, ovf_total - o0, key_on);
      chk($sformatf("vec%0d_ev_count", k), mon_q.size() - m0, vecs[k].ev_v);
      if (vecs[k].ev_v && mon_q.size() > m0) chk($sformatf("vec%0d_ev", k), mon_q[m0], vecs[k].ev);
      chk($sformatf("vec%0d_err", k), err_total - e0, vecs[k].err);
      chk($sformatf("vec%0d_ovf", k), ovf_total - o0, vecs[k].ovf);
      chk($sformatf("vec%0d_key_on", k), key_on, vecs[k].on);
      chk($sformatf("vec%0d_key_code", k), key_code, vecs[k].kc);
    end

    pulse_clr();
    $display("key_clr: key_on=%b key_code=%h", key_on, key_code);
    chk("clr_key_on", key_on, 0);
    chk("clr_key_code", key_code, 0);

    // Short low glitch on ps2_clk while data is low must not start a frame
    e0 = err_total; m0 = mon_q.size();
    ps2_dat = 1'b0; tick(5);
    ps2_clk = 1'b0; tick(3);
    ps2_clk = 1'b1; tick(20);
    ps2_dat = 1'b1; tick(20);
    send_frame(8'h16, 0, 0);
    $display("glitch: events=%0d err=%0d", mon_q.size() - m0, err_total - e0);
    chk("glitch_err", err_total - e0, 0);
    chk("glitch_ev_count", mon_q.size() - m0, 1);
    if (mon_q.size() > m0) chk("glitch_ev", mon_q[m0], 10'h016);
    chk("glitch_key_code", key_code, kc3(0, 0, 9'h016));

    // Abandoned frame after 4 data bits times out
    e0 = err_total; m0 = mon_q.size();
    send_bits(mk_frame(8'h16, 0, 0), 5);
    ps2_dat = 1'b1;
    tick(TIMEOUT + 100);
    $display("timeout: err=%0d events=%0d", err_total - e0, mon_q.size() - m0);
    chk("timeout_err", err_total - e0, 1);
    chk("timeout_ev_count", mon_q.size() - m0, 0);
    send_frame(8'h16, 0, 0);
    chk("post_timeout_ev_count", mon_q.size() - m0, 1);
    if (mon_q.size() > m0) chk("post_timeout_ev", mon_q[m0], 10'h016);
    chk("post_timeout_err", err_total - e0, 1);

    // Backpressure: 5 makes into a 4-deep FIFO and a 3-slot table
    pulse_clr();
    bp_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B};
    evt_ready = 1'b0;
    o0 = ovf_total; m0 = mon_q.size();
    for (int i = 0; i < 5; i++) send_frame(bp_codes[i], 0, 0);
    $display("backpressure: ovf=%0d evt_valid=%0d key_on=%b", ovf_total - o0, evt_valid, key_on);
    chk("bp_ovf", ovf_total - o0, 2);
    chk("bp_evt_valid", evt_valid, 1);
    chk("bp_head", {evt_ext, evt_break, evt_code}, 10'h01C);
    chk("bp_key_on", key_on, 3'b111);
    chk("bp_key_code", key_code, kc3(9'h021, 9'h032, 9'h01C));
    pulse_clr();
    chk("bp_clr_keeps_fifo", evt_valid, 1);
    evt_ready = 1'b1;
    tick(10);
    chk("bp_drain_count", mon_q.size() - m0, 4);
    for (int i = 0; i < 4; i++)
      if (mon_q.size() > m0 + i) chk($sformatf("bp_drain%0d", i), mon_q[m0 + i], {2'b00, bp_codes[i]});
    chk("bp_empty", evt_valid, 0);

    // Randomized frames against the reference model
    pool = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h1C, 8'h74};
    model_clr(); m_ext = 0; m_brk = 0; m_err = 0; m_ovf = 0;
    e0 = err_total; o0 = ovf_total; m0 = mon_q.size();
    for (int n = 0; n < 70; n++) begin
      pick = $urandom_range(0, 9);
      if (pick < 2) b = 8'hE0;
      else if (pick < 4) b = 8'hF0;
      else b = pool[$urandom_range(0, 5)];
      bs = ($urandom_range(0, 11) == 0);
      bpar = ($urandom_range(0, 11) == 0);
      model_byte(b, bpar, bs);
      send_frame(b, bpar, bs);
      $display("rand %0d: byte %02h bp=%0d bs=%0d key_on=%b key_code=%h", n, b, bpar, bs, key_on, key_code);
      chk($sformatf("rand%0d_key_on", n), key_on, model_on());
      chk($sformatf("rand%0d_key_code", n), key_code, model_kc());
    end
    chk("rand_ev_count", mon_q.size() - m0, m_evq.size());
    for (int i = 0; i < m_evq.size(); i++)
      if (mon_q.size() > m0 + i) chk($sformatf("rand_ev%0d", i), mon_q[m0 + i], m_evq[i]);
    chk("rand_err", err_total - e0, m_err);
    chk("rand_ovf", ovf_total - o0, m_ovf);

    // Asynchronous reset in the middle of a frame
    send_frame(8'h1C, 0, 0);
    send_bits(mk_frame(8'h2D, 0, 0), 4);
    ps2_clk = 1'b0;
    #33 reset = 1'b0;
    #2;
    $display("mid-frame reset: evt_valid=%0d key_on=%b", evt_valid, key_on);
    chk("arst_key_on", key_on, 0);
    chk("arst_key_code", key_code, 0);
    chk("arst_evt", {evt_valid, evt_ext, evt_break, evt_code}, 0);
    chk("arst_err_ovf", {frame_err, overflow}, 0);
    ps2_clk = 1'b1; ps2_dat = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(20);
    e0 = err_total; m0 = mon_q.size();
    send_frame(8'h1E, 0, 0);
    chk("arst_next_ev_count", mon_q.size() - m0, 1);
    if (mon_q.size() > m0) chk("arst_next_ev", mon_q[m0], 10'h01E);
    chk("arst_next_err", err_total - e0, 0);
    chk("arst_next_key_code", key_code, kc3(0, 0, 9'h01E));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_rx_multi.md
Name: ps2_keyboard_rx_multi

Overview:
- Next-generation PS/2 keyboard receiver. Runs entirely in one system clock domain: synchronised, glitch-filtered PS/2 clock and data.
- Includes a framed receive FSM with odd-parity, stop-bit and timeout checking, plus an E0/F0 prefix decoder.
- Outputs a parametrised N-slot held-key table and a buffered scan-event stream with valid/ready handshake.
- Sits between the board PS/2 pins and the room-management control logic.

Parameters:
- N_KEYS, 3: number of simultaneously tracked held keys (1..8).
- FIFO_DEPTH, 4: event FIFO entries (power of 2, >=2).
- FILTER_LEN, 8: consecutive identical samples needed to accept a filtered ps2_clk level change.
- TIMEOUT_CYCLES, 100000: iCLK_50 cycles allowed between falling edges inside a frame (2 ms at 50 MHz).

Ports:
- iCLK_50, in, 1: system clock.
- reset, in, 1: asynchronous active-low reset.
- ps2_clk, in, 1: raw PS/2 clock pin (input only).
- ps2_dat, in, 1: raw PS/2 data pin (input only).
- key_clr, in, 1: synchronous clear of the key table.
- evt_ready, in, 1: consumer accepts the head event.
- evt_valid, out, 1: FIFO non-empty.
- evt_code, out, 8: head event scan code.
- evt_ext, out, 1: head event was E0-prefixed.
- evt_break, out, 1: head event was a release (F0-prefixed).
- key_on, out, N_KEYS: slot occupied.
- key_code, out, 9*N_KEYS: slot i = bits [9i+8:9i] = {ext,code}.
- frame_err, out, 1: one-cycle pulse on a bad frame.
- overflow, out, 1: one-cycle pulse when the table is full on a make, or an event is dropped on a full FIFO.

Behaviour:
- Reset (reset=0, async):
  - All state cleared; FSM in IDLE; prefix flags cleared; FIFO empty.
  - evt_valid=0, evt_code=0, evt_ext=0, evt_break=0.
  - key_on=0, key_code=0, frame_err=0, overflow=0.
  - A reset asserted mid-frame discards the partial frame.
- Input conditioning:
  - Two-flop synchroniser on each pin.
  - Filtered clock changes level only after FILTER_LEN equal consecutive synchronised samples; filter resets to 1.
  - Data is sampled from the synchronised ps2_dat on the cycle a filtered falling edge is detected.
- Frame FSM (advances only on filtered falling edges):
  - IDLE: dat=0 -> DATA with bit counter 0; dat=1 -> stay.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP, dat=1 and parity good: byte complete (cycle T); return to IDLE.
  - STOP, dat=0: frame_err pulse, byte discarded, return to IDLE.
  - Timeout: the counter clears on each falling edge and runs while the FSM is not IDLE. Reaching TIMEOUT_CYCLES forces IDLE with a frame_err pulse; timeout frame_err is independent of PS2_PARITY_CHECK_EN.
- Prefix decoder (registered at T+1):
  - Byte E0: set ext flag, no event.
  - Byte F0: set brk flag, no event.
  - Any other byte: emit event {code, ext, brk}, then clear both flags.
  - Flags persist across frame errors.
- Key table (updated at T+1, visible at T+2):
  - Make, {ext,code} already in a slot: no change (typematic repeat).
  - Make, not present: written to the lowest-index free slot and key_on set. If no slot is free, table unchanged and overflow pulses.
  - Break: the matching slot is cleared (key_on=0, key_code=0). Break with no match: no change.
  - key_clr clears all slots and wins over a simultaneous update.
- Event FIFO:
  - First-word fall-through; a write at T+1 gives evt_valid=1 at T+2.
  - Pop on evt_valid & evt_ready.
  - Push while full without a same-cycle pop: event dropped, overflow pulses.
  - Push while full with a same-cycle pop: both succeed.
  - Pointers wrap modulo FIFO_DEPTH.
  - The table is updated regardless of FIFO state; key_clr does not affect the FIFO.
- Minimum frame spacing is one ps2_clk period, so at most one event is produced per frame.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: odd parity is checked (XOR of 8 data bits and the parity bit must equal 1). On failure, frame_err pulses and the byte is discarded before the decoder.
- Undefined: the parity bit is shifted in and ignored; only stop-bit and timeout errors raise frame_err.

Test Plan:
- Make A: frame 1C, correct parity, evt_ready=1. Expect an event code=1C, ext=0, break=0 at T+2; key_on[0]=1, slot0={0,1C}.
- Extended release: after making 1C then 74, send E0 74, then E0 F0 74. Expect events (74,ext=1,brk=0) and (74,ext=1,brk=1); the 74 slot clears; slot0 still holds 1C.
- Table full: with N_KEYS=3, send makes 16, 1E, 26, 25. Expect slots 16/1E/26, overflow pulse on 25. Then F0 1E followed by 25: 25 fills slot1.
- Bad parity (macro defined): frame 5A with a wrong parity bit. Expect frame_err pulse, no event, no table change. With the macro undefined: event 5A delivered.
- Timeout/glitch: abort a frame after 4 data bits; after 100000 cycles expect frame_err and IDLE, then a clean 16 frame decodes. A 3-cycle low glitch on ps2_clk produces no edge.
- FIFO backpressure: hold evt_ready=0 and send 5 makes with FIFO_DEPTH=4. Expect 4 queued events and an overflow pulse on the 5th. Releasing evt_ready drains them in order; the table still holds the first 3 keys.
